serial_command_decoder: RTL and testbench
=========================================

// Module: serial_command_decoder
//
// PURPOSE
//   Parses framed command bytes from the UART receiver into register write strobes.
//   Sits directly upstream of control_register and drives its write / write_register inputs.
//   Frame format: SYNC, ADDR, DATA, CHK, where CHK = SYNC ^ ADDR ^ DATA.
//   Malformed or stalled frames are discarded and counted, so no partial write ever occurs.
//
// PARAMETERS
//   SYNC_BYTE       8'hA5    first byte of every frame
//   TIMEOUT_CYCLES  100_000  max clk cycles allowed between bytes inside one frame (>=2)
//   ERR_CNT_W       8        width of the saturating error counter
//
// PORTS
//   clk             in   1          system clock
//   reset_n         in   1          synchronous, active-low reset
//   rx_data         in   8          received byte
//   rx_valid        in   1          1-cycle strobe, rx_data valid
//   write           out  1          1-cycle pulse: frame accepted
//   write_addr      out  8          ADDR of the last accepted frame
//   write_data      out  8          DATA of the last accepted frame
//   write_register  out  1          write_data[0]; feeds control_register
//   frame_error     out  1          1-cycle pulse: bad checksum or timeout
//   error_count     out  ERR_CNT_W  saturating count of frame errors
//   busy            out  1          high whenever state != IDLE
//   tx_data         out  8          (CMD_ACK_EN only) response byte
//   tx_valid        out  1          (CMD_ACK_EN only) response pending
//   tx_ready        in   1          (CMD_ACK_EN only) UART TX accepts byte
//
// BEHAVIOUR
//   Reset (reset_n=0 at posedge):
//     - state=IDLE; every output = 0, including error_count and tx_valid.
//     - A reset mid-frame drops the partial frame silently.
//   FSM states: IDLE -> ADDR -> DATA -> CHK -> IDLE; each state advances only on rx_valid.
//     - IDLE: a byte == SYNC_BYTE goes to ADDR. Any other byte is discarded; no error.
//     - ADDR: latch the byte into addr_q; go to DATA.
//     - DATA: latch the byte into data_q; go to CHK.
//     - CHK, byte == SYNC^addr_q^data_q:
//         - The next cycle pulses write for exactly 1 cycle.
//         - write_addr / write_data / write_register update in that same cycle.
//     - CHK, mismatch: frame_error pulses next cycle; no write.
//     - Leaving CHK: the state always returns to IDLE, including on a mismatch.
//   Latency: write asserts 1 clk after the rx_valid that carries CHK.
//   Outputs write_addr/write_data/write_register hold until the next accepted frame.
//   Timeout counter:
//     - Clears on every rx_valid and while in IDLE.
//     - Increments each cycle in ADDR/DATA/CHK without rx_valid.
//     - On reaching TIMEOUT_CYCLES: state -> IDLE and frame_error pulses next cycle.
//   Simultaneous rx_valid and timeout in the same cycle: rx_valid wins. The byte is consumed and the counter clears.
//   error_count: +1 per frame_error pulse, saturates at 2^ERR_CNT_W-1 (no wrap).
//   Back-to-back frames: a SYNC byte arriving the cycle after CHK is accepted normally.
//   busy: registered, equals (state != IDLE).
//
// CONFIGURATION
//   CMD_ACK_EN defined:
//     - tx_* ports exist.
//     - Accepted frame loads tx_data=8'h06 (ACK); checksum failure loads 8'h15 (NAK).
//       Either load sets tx_valid in the same cycle as write or frame_error.
//     - Timeout sends no response.
//     - tx_valid holds until tx_ready=1 is sampled while tx_valid=1.
//     - A new response while one is pending overwrites tx_data; tx_valid stays 1.
//   CMD_ACK_EN undefined:
//     - tx_* ports and all response logic are absent.
//     - Decode behaviour is identical.
//
// TESTING
//   1. Bytes A5,01,01,A5 -> write=1 one cycle; write_addr=01, write_data=01, write_register=1.
//   2. Bytes A5,01,01,00 -> frame_error=1 one cycle; write stays 0; error_count=1.
//   3. Bytes 3C,7E then A5,02,00,A7 -> garbage ignored, no error; write pulses, addr=02, data=00.
//   4. A5,01 then no byte for TIMEOUT_CYCLES -> frame_error pulse, busy=0; next valid frame accepted.
//   5. Timeout forced 2^ERR_CNT_W+3 times -> error_count holds at max, no wrap.
//   6. reset_n=0 after A5,01 -> all outputs 0; bytes 01,A5 afterwards produce no write.
//      With CMD_ACK_EN and tx_ready=0: frame 1 -> tx_data=06, tx_valid held until tx_ready=1.

Source files
------------

// File: rtl/serial_command_decoder.sv
// serial_command_decoder
//   Turns framed UART bytes (SYNC, ADDR, DATA, CHK with CHK = SYNC^ADDR^DATA)
//   into single-cycle register write strobes for control_register.
//   A frame with a bad checksum, or one that stalls between bytes, is dropped
//   whole and counted, so a partial frame never produces a write.
//   Optional feature macro: CMD_ACK_EN adds an ACK/NAK response byte port
//   (tx_data / tx_valid / tx_ready). Without it the decode path is unchanged.

module serial_command_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100_000,
  parameter int         ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 write,
  output logic [7:0]           write_addr,
  output logic [7:0]           write_data,
  output logic                 write_register,
  output logic                 frame_error,
  output logic [ERR_CNT_W-1:0] error_count,
`ifdef CMD_ACK_EN
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
`endif
  output logic                 busy
);

  // The timer only has to reach TIMEOUT_CYCLES-1: the cycle that would take
  // it to TIMEOUT_CYCLES is the one that abandons the frame.
  localparam int                 TIMER_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CHK
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [7:0]         addr_q;
  logic [7:0]         data_q;

  logic [7:0]         expected_chk;
  logic               in_frame;
  logic               timeout_hit;
  logic               frame_accept;
  logic               frame_reject;

  // Frame events for this cycle; a byte arriving on the last allowed cycle
  // suppresses the timeout because timeout_hit requires !rx_valid.
  always_comb begin
    expected_chk = SYNC_BYTE ^ addr_q ^ data_q;
    in_frame     = (state != S_IDLE);
    timeout_hit  = in_frame && !rx_valid && (timer == TIMEOUT_LAST);
    frame_accept = (state == S_CHK) && rx_valid && (rx_data == expected_chk);
    frame_reject = (state == S_CHK) && rx_valid && (rx_data != expected_chk);
  end

  // Inter-byte stall timer: runs only while inside a frame with no byte arriving.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (!in_frame || rx_valid || timeout_hit) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  // Frame sequencer; busy is written alongside state so it mirrors state != IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (timeout_hit) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else if (rx_valid) begin
      case (state)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state <= S_ADDR;
            busy  <= 1'b1;
          end
        end
        S_ADDR: begin
          addr_q <= rx_data;
          state  <= S_DATA;
        end
        S_DATA: begin
          data_q <= rx_data;
          state  <= S_CHK;
        end
        S_CHK: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Write strobe and the held register image of the last accepted frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      write          <= 1'b0;
      write_addr     <= '0;
      write_data     <= '0;
      write_register <= 1'b0;
    end else begin
      write <= frame_accept;
      if (frame_accept) begin
        write_addr     <= addr_q;
        write_data     <= data_q;
        write_register <= data_q[0];
      end
    end
  end

  // Error pulse and saturating error counter, updated in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_error <= 1'b0;
      error_count <= '0;
    end else begin
      frame_error <= timeout_hit || frame_reject;
      if ((timeout_hit || frame_reject) && (error_count != ERR_MAX)) begin
        error_count <= error_count + ERR_CNT_W'(1);
      end
    end
  end

`ifdef CMD_ACK_EN
  // Response byte: ACK on accept, NAK on checksum failure, nothing on timeout.
  // A fresh response overrides the ready handshake so it is never lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (frame_accept) begin
      tx_data  <= 8'h06;
      tx_valid <= 1'b1;
    end else if (frame_reject) begin
      tx_data  <= 8'h15;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end
`else
  // No response path in this build; decoding is unaffected.
`endif

endmodule

// File: tb/tb_serial_command_decoder.sv
// tb_serial_command_decoder
//   Scoreboard bench: each frame pushes its expected outcome (write or
//   frame_error, with the exact cycle it must appear), and a negedge monitor
//   pops and compares whenever the DUT pulses write or frame_error.

module tb_serial_command_decoder;

  localparam int T = 16;

  logic       clk;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       write;
  logic [7:0] write_addr;
  logic [7:0] write_data;
  logic       write_register;
  logic       frame_error;
  logic [7:0] error_count;
  logic       busy;
`ifdef CMD_ACK_EN
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
`endif

  typedef struct {
    bit         is_write;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t sb[$];
  ev_t ev;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  serial_command_decoder #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(T),
    .ERR_CNT_W(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .write(write),
    .write_addr(write_addr),
    .write_data(write_data),
    .write_register(write_register),
    .frame_error(frame_error),
    .error_count(error_count),
`ifdef CMD_ACK_EN
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write / frame_error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (write || frame_error) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event: write=%0b frame_error=%0b cycle=%0d, required no event",
                 write, frame_error, cyc);
      end else begin
        ev = sb.pop_front();
        if (write !== ev.is_write || frame_error !== !ev.is_write || cyc != ev.cyc) begin
          errors++;
          $display("[TB] FAIL event_kind: write=%0b frame_error=%0b cycle=%0d, required write=%0b cycle=%0d",
                   write, frame_error, cyc, ev.is_write, ev.cyc);
        end else if (ev.is_write &&
                     (write_addr !== ev.addr || write_data !== ev.data ||
                      write_register !== ev.data[0])) begin
          errors++;
          $display("[TB] FAIL write_fields: addr=%02h data=%02h reg=%0b, required addr=%02h data=%02h reg=%0b",
                   write_addr, write_data, write_register, ev.addr, ev.data, ev.data[0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic push_event(input bit is_write, input logic [7:0] a,
                            input logic [7:0] d, input int at);
    ev_t e;
    e.is_write = is_write;
    e.addr     = a;
    e.data     = d;
    e.cyc      = at;
    sb.push_back(e);
  endtask

  // Sends a whole frame back to back and queues the outcome the checksum implies.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(c);
    push_event(c == (8'hA5 ^ a ^ d), a, d, cyc);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d events pending, required 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string name, input logic [7:0] exp);
    checks++;
    if (error_count !== exp) begin
      errors++;
      $display("[TB] FAIL %s: error_count=%0d, required %0d", name, error_count, exp);
    end
  endtask

  task automatic check_busy(input string name, input logic exp);
    checks++;
    if (busy !== exp) begin
      errors++;
      $display("[TB] FAIL %s: busy=%0b, required %0b", name, busy, exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({write, write_addr, write_data, write_register, frame_error, error_count, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: w=%0b a=%02h d=%02h r=%0b fe=%0b ec=%0d busy=%0b, required all 0",
               write, write_addr, write_data, write_register, frame_error, error_count, busy);
    end
`ifdef CMD_ACK_EN
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_tx: tx_valid=%0b tx_data=%02h, required 0", tx_valid, tx_data);
    end
`endif
  endtask

  task automatic test_valid_frame();
    send_frame(8'h01, 8'h01, 8'hA5);
    wait_drain();
    check_count("valid_frame_count", 8'd0);
    checks++;
    if (write_addr !== 8'h01 || write_data !== 8'h01 || write_register !== 1'b1) begin
      errors++;
      $display("[TB] FAIL valid_frame_hold: addr=%02h data=%02h reg=%0b, required 01 01 1",
               write_addr, write_data, write_register);
    end
  endtask

  task automatic test_bad_checksum();
    send_frame(8'h01, 8'h01, 8'h00);
    wait_drain();
    check_count("bad_checksum_count", 8'd1);
    check_busy("bad_checksum_idle", 1'b0);
  endtask

  task automatic test_garbage();
    send_byte(8'h3C);
    send_byte(8'h7E);
    check_busy("garbage_idle", 1'b0);
    send_frame(8'h02, 8'h00, 8'hA7);
    wait_drain();
    check_count("garbage_count", 8'd1);
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h01);
    push_event(1'b0, 8'h00, 8'h00, cyc + T);
    repeat (T - 1) @(posedge clk);
    #1;
    check_busy("timeout_not_yet", 1'b1);
    @(posedge clk);
    #1;
    check_busy("timeout_idle", 1'b0);
    wait_drain();
    check_count("timeout_count", 8'd2);
    send_frame(8'h10, 8'h33, 8'h86);
    wait_drain();
  endtask

  // Each byte lands on the very cycle the timer would expire; rx_valid wins.
  task automatic test_timeout_boundary();
    send_byte(8'hA5);
    repeat (T - 1) @(posedge clk);
    #1;
    send_byte(8'h01);
    repeat (T - 1) @(posedge clk);
    #1;
    send_byte(8'h01);
    repeat (T - 1) @(posedge clk);
    #1;
    send_byte(8'hA5);
    push_event(1'b1, 8'h01, 8'h01, cyc);
    wait_drain();
    check_count("boundary_count", 8'd2);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 259; i++) begin
      send_byte(8'hA5);
      push_event(1'b0, 8'h00, 8'h00, cyc + T);
      repeat (T) @(posedge clk);
      #1;
    end
    wait_drain();
    check_count("saturation_count", 8'hFF);
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5);
    send_byte(8'h01);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    send_byte(8'h01);
    send_byte(8'hA5);
    repeat (5) @(posedge clk);
    #1;
    check_busy("reset_then_sync", 1'b1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_busy("reset_again_idle", 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h20, 8'h40, 8'hC5);
    send_frame(8'h21, 8'h42, 8'hA5 ^ 8'h21 ^ 8'h42);
    wait_drain();
    check_count("back_to_back_count", 8'd0);
  endtask

`ifdef CMD_ACK_EN
  task automatic test_ack();
    tx_ready = 1'b0;
    send_frame(8'h05, 8'h07, 8'hA5 ^ 8'h05 ^ 8'h07);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h06) begin
      errors++;
      $display("[TB] FAIL ack_load: tx_valid=%0b tx_data=%02h, required 1 06", tx_valid, tx_data);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (tx_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ack_hold: tx_valid=%0b, required 1", tx_valid);
    end
    send_frame(8'h05, 8'h07, 8'h00);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h15) begin
      errors++;
      $display("[TB] FAIL nak_overwrite: tx_valid=%0b tx_data=%02h, required 1 15", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_release: tx_valid=%0b, required 0", tx_valid);
    end
    send_byte(8'hA5);
    push_event(1'b0, 8'h00, 8'h00, cyc + T);
    wait_drain();
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_no_response: tx_valid=%0b, required 0", tx_valid);
    end
  endtask
`endif

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
`ifdef CMD_ACK_EN
    tx_ready = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    test_valid_frame();
    test_bad_checksum();
    test_garbage();
    test_timeout();
    test_timeout_boundary();
    test_saturation();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef CMD_ACK_EN
    test_ack();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
